// File: rtl/decoder_write_queue.sv
// decoder_write_queue
//   Upstream feeder for the 2-to-4 structural decoder. Write requests
//   (2-bit decoder address + data) are buffered in a DEPTH-entry FIFO and
//   issued one per cycle as a registered enable pulse with addr0/addr1/wr_data.
//   Every accepted request produces exactly one enable pulse, in order.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset (discards all queued entries)
//   in_valid   request present on in_addr/in_data
//   in_ready   queue can accept a request this cycle
//   in_addr    decoder address (bit0 -> addr0, bit1 -> addr1)
//   in_data    write data
//   stall      downstream busy; suppresses issue
//   enable     one-cycle pulse per issued request
//   addr0      decoder address bit 0 (holds between pulses)
//   addr1      decoder address bit 1 (holds between pulses)
//   wr_data    data paired with the current enable pulse (holds between pulses)
//   count      queued, not-yet-issued entries
//   issued_cnt saturating issue counter, present only when
//              DECODER_QUEUE_STATS_EN is defined
//
// Handshake: a request transfers on a rising clk edge where in_valid and
// in_ready are both high. in_ready depends only on the registered count, so
// it never looks at in_valid, and a pop on the same edge does not free a slot
// for that edge's push (no pass-through when full).

module decoder_write_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_addr,
  input  logic [DATA_W-1:0] in_data,
  input  logic              stall,
  output logic              enable,
  output logic              addr0,
  output logic              addr1,
  output logic [DATA_W-1:0] wr_data,
`ifdef DECODER_QUEUE_STATS_EN
  output logic [7:0]        issued_cnt,
`endif
  output logic [CNT_W-1:0]  count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [1:0]        mem_addr [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              push;
  logic              pop;

  // Both decisions use the pre-edge count: no push-to-issue bypass on an
  // empty queue and no push into a full queue even if it is popping.
  assign in_ready = (count != CNT_W'(DEPTH));
  assign push     = in_valid && in_ready;
  assign pop      = (count != '0) && !stall;

  // Storage needs no reset: entries are only visible through count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wr_ptr] <= in_addr;
      mem_data[wr_ptr] <= in_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally with no bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      enable  <= 1'b0;
      addr0   <= 1'b0;
      addr1   <= 1'b0;
      wr_data <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end

      if (pop) begin
        rd_ptr  <= rd_ptr + PTR_W'(1);
        enable  <= 1'b1;
        addr0   <= mem_addr[rd_ptr][0];
        addr1   <= mem_addr[rd_ptr][1];
        wr_data <= mem_data[rd_ptr];
      end else begin
        // Address and data hold so the decoder inputs stay quiet between pulses.
        enable <= 1'b0;
      end

      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef DECODER_QUEUE_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      issued_cnt <= 8'd0;
    end else if (pop && (issued_cnt != 8'hFF)) begin
      issued_cnt <= issued_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_decoder_write_queue.sv
// Directed bench for decoder_write_queue: a scoreboard queue holds the
// {addr, data} of every accepted request; a negedge monitor pops and
// compares on each enable pulse.

module tb_decoder_write_queue;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 8;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  logic              clk;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_addr;
  logic [DATA_W-1:0] in_data;
  logic              stall;
  logic              enable;
  logic              addr0;
  logic              addr1;
  logic [DATA_W-1:0] wr_data;
  logic [CNT_W-1:0]  count;
`ifdef DECODER_QUEUE_STATS_EN
  logic [7:0]        issued_cnt;
`endif

  int errors = 0;
  int checks = 0;
  int accepted = 0;
  int pulses = 0;

  logic [DATA_W+1:0] exp_q[$];

  decoder_write_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_addr    (in_addr),
    .in_data    (in_data),
    .stall      (stall),
    .enable     (enable),
    .addr0      (addr0),
    .addr1      (addr1),
    .wr_data    (wr_data),
`ifdef DECODER_QUEUE_STATS_EN
    .issued_cnt (issued_cnt),
`endif
    .count      (count)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- check helper ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one edge; scoreboard it only if in_ready is high.
  task automatic push_req(input logic [1:0] a, input logic [DATA_W-1:0] d);
    in_valid = 1'b1;
    in_addr  = a;
    in_data  = d;
    if (in_ready) begin
      exp_q.push_back({a, d});
      accepted++;
    end
    tick();
    in_valid = 1'b0;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!reset && enable) begin
      pulses++;
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_pulse: got addr=%0d data=%0h expected no pulse",
               {addr1, addr0}, wr_data);
      end
      if (exp_q.size() != 0) begin
        logic [DATA_W+1:0] e;
        e = exp_q.pop_front();
        checks++;
        assert ({addr1, addr0, wr_data} === e) else begin
          errors++;
          $error("FAIL issue_order: got %0h expected %0h", {addr1, addr0, wr_data}, e);
        end
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_addr  = 2'd0;
    in_data  = '0;
    stall    = 1'b0;
    #12;
    chk("reset_enable", enable, 0);
    chk("reset_count", count, 0);
    chk("reset_in_ready", in_ready, 1);
    reset = 1'b0;

    // Idle five cycles.
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_enable", enable, 0);
      chk("idle_addr0", addr0, 0);
      chk("idle_addr1", addr1, 0);
      chk("idle_wr_data", wr_data, 0);
      chk("idle_count", count, 0);
      chk("idle_in_ready", in_ready, 1);
    end

    // Single push: enable after the second edge, for one cycle.
    push_req(2'b10, 8'hA5);
    chk("single_enable_n", enable, 0);
    chk("single_count_n", count, 1);
    tick();
    chk("single_enable_n1", enable, 1);
    chk("single_addr1", addr1, 1);
    chk("single_addr0", addr0, 0);
    chk("single_data", wr_data, 8'hA5);
    chk("single_count_n1", count, 0);
    tick();
    chk("single_enable_n2", enable, 0);
    chk("single_hold_data", wr_data, 8'hA5);

    // Fill under stall, reject the fifth request, then drain in order.
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push_req(2'(i), 8'h10 + 8'(i));
      chk("fill_no_enable", enable, 0);
    end
    chk("full_count", count, 4);
    chk("full_in_ready", in_ready, 0);
    push_req(2'd1, 8'hEE);
    chk("full_count_after_5th", count, 4);
    stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("drain_enable", enable, 1);
      chk("drain_count", count, 3 - i);
    end
    tick();
    chk("drain_done_enable", enable, 0);
    chk("drain_exp_empty", exp_q.size(), 0);

    // Back-to-back traffic: ten consecutive pulses through the pointer wrap.
    for (int i = 0; i < 10; i++) begin
      push_req(2'(i % 4), 8'h20 + 8'(i));
      chk("stream_count_le1", (count <= 1), 1);
      if (i >= 1) chk("stream_enable", enable, 1);
    end
    tick();
    chk("stream_last_enable", enable, 1);
    chk("stream_last_data", wr_data, 8'h29);
    tick();
    chk("stream_end_enable", enable, 0);

    // Asynchronous reset between edges discards queued work.
    stall = 1'b1;
    for (int i = 0; i < 3; i++) push_req(2'(3 - i), 8'h70 + 8'(i));
    chk("prereset_count", count, 3);
    #3;
    reset = 1'b1;
    #1;
    chk("async_enable", enable, 0);
    chk("async_addr0", addr0, 0);
    chk("async_addr1", addr1, 0);
    chk("async_wr_data", wr_data, 0);
    chk("async_count", count, 0);
    chk("async_in_ready", in_ready, 1);
    exp_q.delete();
    accepted = pulses;
    tick();
    reset = 1'b0;
    stall = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("post_reset_enable", enable, 0);
      chk("post_reset_count", count, 0);
    end

`ifdef DECODER_QUEUE_STATS_EN
    // Saturating issue counter.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.delete();
    pulses = 0;
    accepted = 0;
    chk("stats_reset", issued_cnt, 0);
    for (int i = 0; i < 260; i++) begin
      push_req(2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
      if (i == 100) chk("stats_mid", issued_cnt, 100);
    end
    tick();
    tick();
    chk("stats_saturate", issued_cnt, 255);
    tick();
    chk("stats_hold", issued_cnt, 255);
    #3;
    reset = 1'b1;
    #1;
    chk("stats_async_reset", issued_cnt, 0);
    tick();
    reset = 1'b0;
`endif

    // Random-data smoke run with random stall.
    for (int i = 0; i < 40; i++) begin
      stall = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1) == 1)
        push_req(2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
      else
        tick();
      chk("rand_count_max", (count <= DEPTH), 1);
    end
    stall = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk("final_exp_empty", exp_q.size(), 0);
    chk("final_pulses", pulses, accepted);
    chk("final_count", count, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog: always reach the summary line.
  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
